// File: rtl/bitstream_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
package bitstream_loader_pkg;

    localparam int WORD_W = 8;
    localparam int BITS_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CHECK   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    // Number of bits of the final host word that actually reach the chain.
    function automatic logic [BITS_W-1:0] last_word_bits(input int chain_len);
        if ((chain_len % WORD_W) == 0) begin
            return BITS_W'(WORD_W);
        end else begin
            return BITS_W'(chain_len % WORD_W);
        end
    endfunction

endpackage

// File: rtl/bitstream_loader_shifter.sv
// Holds the current host word and how many of its bits remain to be shifted out.
module loader_shifter
    import bitstream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BITS_W-1:0] load_bits,
    input  logic              shift,
    output logic              bit_out,
    output logic [BITS_W-1:0] bits_left
);

    logic [WORD_W-1:0] sreg_r;
    logic [BITS_W-1:0] cnt_r;

    // Shift register: a load replaces the final unshifted bit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (clear) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            sreg_r <= load_data;
            cnt_r  <= load_bits;
        end else if (shift && (cnt_r != '0)) begin
            sreg_r <= {1'b0, sreg_r[WORD_W-1:1]};
            cnt_r  <= cnt_r - BITS_W'(1);
        end
    end

    assign bit_out   = sreg_r[0];
    assign bits_left = cnt_r;

endmodule

// File: rtl/bitstream_loader.sv
// Streams host bytes LSB-first into the fabric scan chain, verifies an XOR
// checksum, then releases the fabric reset after a fixed hold time.
module bitstream_loader
    import bitstream_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 96,
    parameter int RST_HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              prog_en,
    output logic              prog_in,
    output logic              fabric_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_CW  = $clog2(CHAIN_LEN + 1);
    localparam int WORD_CW = $clog2(NWORDS + 1);
    localparam int HOLD_CW = $clog2(RST_HOLD + 1);

    localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(CHAIN_LEN - 1);
    localparam logic [WORD_CW-1:0] NWORDS_C  = WORD_CW'(NWORDS);
    localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(NWORDS - 1);
    localparam logic [HOLD_CW-1:0] LAST_HOLD = HOLD_CW'(RST_HOLD - 1);

    state_t               state_r;
    state_t               state_s;
    logic [BIT_CW-1:0]    bit_cnt_r;
    logic [WORD_CW-1:0]   word_cnt_r;
    logic [WORD_W-1:0]    csum_r;
    logic [HOLD_CW-1:0]   hold_cnt_r;
    logic                 start_ok_s;
    logic                 accept_s;
    logic                 shift_bit_s;
    logic [BITS_W-1:0]    bits_left_s;
    logic [BITS_W-1:0]    load_bits_s;

    assign start_ok_s  = start && (state_r inside {S_IDLE, S_DONE, S_ERROR});
    assign accept_s    = word_valid && word_ready;
    assign load_bits_s = (word_cnt_r == LAST_WORD) ? last_word_bits(CHAIN_LEN) : BITS_W'(WORD_W);

    loader_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok_s),
        .load      (accept_s && (state_r == S_LOAD)),
        .load_data (word_data),
        .load_bits (load_bits_s),
        .shift     (prog_en),
        .bit_out   (shift_bit_s),
        .bits_left (bits_left_s)
    );

    // Outputs decode straight from registered state so reset removes them asynchronously.
    assign prog_en    = (state_r == S_LOAD) && (bits_left_s != '0);
    assign prog_in    = prog_en && shift_bit_s;
    assign fabric_rst = (state_r != S_DONE);
    assign busy       = state_r inside {S_LOAD, S_CHECK, S_RELEASE};
    assign done       = (state_r == S_DONE);
    assign error      = (state_r == S_ERROR);

    // Host handshake: refill when at most one bit is left so words stream without a gap.
    always_comb begin
        word_ready = 1'b0;
        case (state_r)
            S_LOAD:  word_ready = (bits_left_s <= BITS_W'(1)) && (word_cnt_r < NWORDS_C);
            S_CHECK: word_ready = 1'b1;
            default: word_ready = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_s = S_LOAD;
                else       state_s = state_r;
            end
            S_LOAD: begin
                if (prog_en && (bit_cnt_r == LAST_BIT)) state_s = S_CHECK;
                else                                    state_s = S_LOAD;
            end
            S_CHECK: begin
                if (accept_s) state_s = (word_data == csum_r) ? S_RELEASE : S_ERROR;
                else          state_s = S_CHECK;
            end
            S_RELEASE: begin
                if (hold_cnt_r == LAST_HOLD) state_s = S_DONE;
                else                         state_s = S_RELEASE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Bit, word and checksum accounting for the current load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= '0;
            word_cnt_r <= '0;
            csum_r     <= '0;
        end else if (start_ok_s) begin
            bit_cnt_r  <= '0;
            word_cnt_r <= '0;
            csum_r     <= '0;
        end else if (state_r == S_LOAD) begin
            if (prog_en) bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
            if (accept_s) begin
                word_cnt_r <= word_cnt_r + WORD_CW'(1);
                csum_r     <= csum_r ^ word_data;
            end
        end
    end

    // Reset-hold timer, running only while in RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       hold_cnt_r <= '0;
        else if (state_r == S_RELEASE) hold_cnt_r <= hold_cnt_r + HOLD_CW'(1);
        else                           hold_cnt_r <= '0;
    end

endmodule

// File: tb/tb_bitstream_loader.sv
// Randomized self-checking bench for bitstream_loader with 96-bit and 20-bit chains.
module tb_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, word_valid;
    logic [7:0] word_data;
    int         sel;
    logic       wr96, pe96, pi96, fr96, b96, d96, e96;
    logic       wr20, pe20, pi20, fr20, b20, d20, e20;
    logic       wr, pe, pi, fr, bz, dn, er;
    logic [7:0] words [0:15];
    bit         got_bits[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    bitstream_loader #(.CHAIN_LEN(96), .RST_HOLD(4)) dut96 (
        .clk(clk), .rst(rst), .start(start && (sel == 0)), .word_valid(word_valid && (sel == 0)),
        .word_data(word_data), .word_ready(wr96), .prog_en(pe96), .prog_in(pi96),
        .fabric_rst(fr96), .busy(b96), .done(d96), .error(e96));

    bitstream_loader #(.CHAIN_LEN(20), .RST_HOLD(4)) dut20 (
        .clk(clk), .rst(rst), .start(start && (sel == 1)), .word_valid(word_valid && (sel == 1)),
        .word_data(word_data), .word_ready(wr20), .prog_en(pe20), .prog_in(pi20),
        .fabric_rst(fr20), .busy(b20), .done(d20), .error(e20));

    assign wr = (sel != 0) ? wr20 : wr96;
    assign pe = (sel != 0) ? pe20 : pe96;
    assign pi = (sel != 0) ? pi20 : pi96;
    assign fr = (sel != 0) ? fr20 : fr96;
    assign bz = (sel != 0) ? b20  : b96;
    assign dn = (sel != 0) ? d20  : d96;
    assign er = (sel != 0) ? e20  : e96;

    // Drives one full load; expected bits and checksum come from the byte array.
    task automatic run_load(input string name, input int chain, input int stall_word,
                            input bit bad, input int start_mid, input int abort_bit);
        int nwords, idx, stall_left, first_pe, last_pe, cyc, acc_cyc, fin_cyc;
        int pe_cnt, status_bad, bit_err, exp_span;
        logic [7:0] csum;
        bit exp_bits[$];
        bit csent, stalled;
        nwords = (chain + 7) / 8;
        csum = 8'h00;
        idx = 0; stall_left = 0; first_pe = -1; last_pe = -1; cyc = 0;
        acc_cyc = -1; fin_cyc = -1; pe_cnt = 0; status_bad = 0; bit_err = 0;
        csent = 1'b0; stalled = 1'b0;
        got_bits.delete();
        sel = (chain == 20) ? 1 : 0;
        for (int i = 0; i < nwords; i++) csum ^= words[i];
        for (int i = 0; i < chain; i++) exp_bits.push_back(words[i / 8][i % 8]);

        start = 1'b1; word_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000) begin
            if (pe) begin
                got_bits.push_back(pi);
                pe_cnt++;
                if (first_pe < 0) first_pe = cyc;
                last_pe = cyc;
            end
            if (abort_bit > 0 && got_bits.size() == abort_bit) begin
                rst = 1'b1;
                #1;
                tests_run++;
                if ({wr, pe, pi, fr, bz, dn, er} !== 7'b0001000) begin
                    tests_failed++;
                    $display("FAIL %s abort_outputs: got %b expected 0001000", name, {wr, pe, pi, fr, bz, dn, er});
                end
                @(negedge clk);
                rst = 1'b0; word_valid = 1'b0; start = 1'b0;
                return;
            end
            if (acc_cyc >= 0 && (dn || er)) begin
                fin_cyc = cyc;
                break;
            end
            if (acc_cyc < 0 && (!bz || !fr)) status_bad++;
            start = (cyc == start_mid);
            if (idx < nwords) begin
                if (!stalled && idx == stall_word && wr) begin
                    stall_left = 5;
                    stalled = 1'b1;
                end
                word_valid = (stall_left == 0);
                word_data  = words[idx];
                if (stall_left > 0) stall_left--;
            end else if (!csent) begin
                word_valid = 1'b1;
                word_data  = bad ? (csum ^ 8'h5A) : csum;
            end else begin
                word_valid = 1'b0;
            end
            if (word_valid && wr) begin
                if (idx < nwords) idx++;
                else begin
                    csent = 1'b1;
                    acc_cyc = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; word_valid = 1'b0;

        tests_run++;
        if (fin_cyc < 0) begin
            tests_failed++;
            $display("FAIL %s completion: got no done/error expected one within budget", name);
        end
        if (got_bits.size() != exp_bits.size()) bit_err = 1;
        else for (int i = 0; i < chain; i++) if (got_bits[i] != exp_bits[i]) bit_err++;
        tests_run++;
        if (bit_err != 0) begin
            tests_failed++;
            $display("FAIL %s bit_sequence: got %0d bits with %0d errors expected %0d exact bits", name, got_bits.size(), bit_err, chain);
        end
        tests_run++;
        if (pe_cnt != chain) begin
            tests_failed++;
            $display("FAIL %s prog_en_count: got %0d expected %0d", name, pe_cnt, chain);
        end
        tests_run++;
        if (first_pe != 1) begin
            tests_failed++;
            $display("FAIL %s first_bit_latency: got %0d expected 1", name, first_pe);
        end
        exp_span = chain + ((stall_word > 0) ? 5 : 0);
        tests_run++;
        if (last_pe - first_pe + 1 != exp_span) begin
            tests_failed++;
            $display("FAIL %s prog_en_span: got %0d expected %0d", name, last_pe - first_pe + 1, exp_span);
        end
        tests_run++;
        if (status_bad != 0) begin
            tests_failed++;
            $display("FAIL %s busy_fabric_rst_during_load: got %0d bad cycles expected 0", name, status_bad);
        end
        if (!bad) begin
            tests_run++;
            if ({dn, er, fr, bz, wr} !== 5'b10000) begin
                tests_failed++;
                $display("FAIL %s done_status: got %b expected 10000", name, {dn, er, fr, bz, wr});
            end
            tests_run++;
            if (fin_cyc - acc_cyc != 5) begin
                tests_failed++;
                $display("FAIL %s release_time: got %0d expected 5", name, fin_cyc - acc_cyc);
            end
        end else begin
            tests_run++;
            if ({dn, er, fr, bz, wr} !== 5'b01100) begin
                tests_failed++;
                $display("FAIL %s error_status: got %b expected 01100", name, {dn, er, fr, bz, wr});
            end
            tests_run++;
            if (fin_cyc - acc_cyc != 1) begin
                tests_failed++;
                $display("FAIL %s error_latency: got %0d expected 1", name, fin_cyc - acc_cyc);
            end
        end
    endtask

    task automatic randomize_words(input int n);
        for (int i = 0; i < n; i++) words[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 8'h00; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            tests_run++;
            if ({wr, pe, pi, fr, bz, dn, er} !== 7'b0001000) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got %b expected 0001000", s, {wr, pe, pi, fr, bz, dn, er});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({wr, pe, pi, fr, bz, dn, er} !== 7'b0001000) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b expected 0001000", {wr, pe, pi, fr, bz, dn, er});
        end
    endtask

    task automatic test_continuous();
        randomize_words(12);
        run_load("continuous", 96, -1, 1'b0, -1, 0);
    endtask

    task automatic test_stall();
        run_load("stall", 96, 5, 1'b0, -1, 0);
    endtask

    task automatic test_partial_word();
        words[0] = 8'hFF; words[1] = 8'h0F; words[2] = 8'hF3;
        run_load("partial", 20, -1, 1'b0, -1, 0);
        tests_run++;
        if (got_bits.size() != 20) begin
            tests_failed++;
            $display("FAIL partial_last_bits: got %0d bits expected 20", got_bits.size());
        end else if ({got_bits[19], got_bits[18], got_bits[17], got_bits[16]} !== 4'b0011) begin
            tests_failed++;
            $display("FAIL partial_last_bits: got %b expected 0011",
                     {got_bits[19], got_bits[18], got_bits[17], got_bits[16]});
        end
    endtask

    task automatic test_bad_checksum();
        randomize_words(12);
        run_load("bad_checksum", 96, -1, 1'b1, -1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({bz, er, fr} !== 3'b101) begin
            tests_failed++;
            $display("FAIL restart_from_error: got busy,error,fabric_rst=%b expected 101", {bz, er, fr});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_abort_reload();
        randomize_words(12);
        run_load("abort", 96, -1, 1'b0, -1, 40);
        run_load("reload", 96, -1, 1'b0, -1, 0);
    endtask

    task automatic test_start_during_load();
        randomize_words(12);
        run_load("start_in_load", 96, -1, 1'b0, 30, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            randomize_words(12);
            run_load("b2b96", 96, (k == 0) ? 3 : -1, 1'b0, -1, 0);
            randomize_words(3);
            run_load("b2b20", 20, -1, 1'b0, -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_partial_word();
        test_bad_checksum();
        test_abort_reload();
        test_start_during_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 96: total configuration bits in the fabric scan chain; legal range 1..4095.
REQ-003 The block SHALL have parameter RST_HOLD, default 4: clk cycles fabric_rst stays high after shifting ends; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1: system clock.
REQ-005 The block SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1: single-cycle request to begin a configuration load.
REQ-007 The block SHALL have port word_valid, input, 1: host word available.
REQ-008 The block SHALL have port word_data, input, 8: host bitstream byte, LSB shifted first.
REQ-009 The block SHALL have port word_ready, output, 1: block accepts word_data this cycle.
REQ-010 The block SHALL have port prog_en, output, 1: scan-chain shift enable.
REQ-011 The block SHALL have port prog_in, output, 1: scan-chain serial data.
REQ-012 The block SHALL have port fabric_rst, output, 1: reset to configured fabric.
REQ-013 The block SHALL have ports busy, done and error, output, 1 each: status flags.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, CHECK, RELEASE, DONE and ERROR.
REQ-015 In IDLE, DONE or ERROR, start=1 SHALL move the block to LOAD next cycle and clear the bit counter, word counter and checksum; start is ignored in every other state.
REQ-016 The block SHALL hold fabric_rst=1 in LOAD, CHECK, RELEASE and ERROR, and at reset.
REQ-017 NWORDS SHALL equal ceil(CHAIN_LEN/8); a word transfers on the cycle word_valid and word_ready are both 1.
REQ-018 In LOAD, word_ready SHALL be 1 when the shifter holds 0 or 1 unshifted bits and fewer than NWORDS words have been accepted, so back-to-back words shift with no bubble.
REQ-019 prog_en SHALL be 1 only in cycles presenting a valid bit on prog_in; the first bit of an accepted word is presented the cycle after acceptance.
REQ-020 On host starvation, prog_en SHALL drop to 0 and no bit SHALL be lost or repeated.
REQ-021 The last word SHALL shift only its CHAIN_LEN mod 8 low bits when that value is nonzero; its upper bits are discarded but still enter the checksum.
REQ-022 After exactly CHAIN_LEN bits have shifted, the block SHALL enter CHECK with prog_en=0.
REQ-023 The checksum SHALL be the 8-bit XOR of all NWORDS accepted words.
REQ-024 In CHECK, word_ready SHALL be 1; the accepted word is the expected checksum.
REQ-025 On a CHECK match the block SHALL go to RELEASE; on a mismatch it SHALL go to ERROR.
REQ-026 RELEASE SHALL last exactly RST_HOLD cycles, then the block enters DONE, where fabric_rst=0 and done=1.
REQ-027 busy SHALL be 1 in LOAD, CHECK and RELEASE; error SHALL be 1 only in ERROR; done SHALL be 1 only in DONE.
REQ-028 word_ready SHALL be 0 in IDLE, RELEASE, DONE and ERROR.

Reset
REQ-029 Reset SHALL force IDLE with fabric_rst=1 and word_ready, prog_en, prog_in, busy, done and error all 0, and SHALL clear all counters.
REQ-030 Reset asserted mid-LOAD SHALL abort the load immediately; prog_en drops asynchronously and partially shifted data is discarded.

Structure
REQ-031 A shared package SHALL hold the state enum and the WORD_W=8 constant.
REQ-032 One sub-module, loader_shifter, SHALL hold the 8-bit shift register and its bit-remaining count.
REQ-033 Counter widths SHALL derive from CHAIN_LEN and RST_HOLD via $clog2.

Verification
REQ-034 With CHAIN_LEN=96, 12 words streamed continuously plus a correct checksum, the bench SHALL see prog_en high for exactly 96 consecutive cycles, LSB-first order on prog_in, and done=1 after RST_HOLD=4 cycles.
REQ-035 With CHAIN_LEN=20, words 0xFF, 0x0F, 0xF3 and checksum 0x03, the bench SHALL see exactly 20 prog_en pulses, with the last 4 bits equal to 0011 (0x3 LSB-first), then done=1.
REQ-036 With word_valid low for 5 cycles mid-stream, the bench SHALL see prog_en low for those cycles and the bit sequence on prog_in unchanged versus the continuous run.
REQ-037 With a wrong checksum word, the bench SHALL see error=1, fabric_rst=1 and done=0; a following start SHALL return the block to LOAD with error=0.
REQ-038 With rst pulsed after bit 40 of 96, the bench SHALL see IDLE with all outputs at reset values; a full reload then SHALL complete with done=1.
REQ-039 With start asserted during LOAD, the bench SHALL see no effect on the bit or word counts.
